// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated 4-bit integer ALU.
//   - WIDTH / OPW : default operand and opcode widths
//   - OP_*        : opcode encodings understood by alu_core
//   - state_t     : arbiter FSM state encoding
package alu_pkg;

   localparam int WIDTH = 4;
   localparam int OPW   = 3;

   localparam logic [OPW-1:0] OP_AND  = 3'b000;
   localparam logic [OPW-1:0] OP_OR   = 3'b001;
   localparam logic [OPW-1:0] OP_XOR  = 3'b010;
   localparam logic [OPW-1:0] OP_XNOR = 3'b011;
   localparam logic [OPW-1:0] OP_NAND = 3'b100;
   localparam logic [OPW-1:0] OP_NOR  = 3'b101;
   localparam logic [OPW-1:0] OP_ADD  = 3'b110;
   localparam logic [OPW-1:0] OP_SUB  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
// Ports:
//   op     in   OPW    opcode (see alu_pkg OP_*)
//   a, b   in   WIDTH  operands
//   result out  WIDTH  result, modulo 2^WIDTH
//   carry  out  1      ADD: carry-out, SUB: borrow (a < b), logic ops: 0
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPW   = alu_pkg::OPW
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   // One extra bit so the MSB of the sum/difference is the carry/borrow.
   logic [WIDTH:0] wide;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      wide   = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_XNOR: result = ~(a ^ b);
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         OP_SUB: begin
            // Zero-extended subtraction wraps into the top bit exactly when a < b.
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU core.
// Accepts one operation at a time (IDLE), executes it for one cycle (EXEC),
// then holds the registered result until the consumer takes it (RESP).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/op/a/b  (N = 0, 1)    request from requester N
//   reqN_ready                       handshake strobe, only for the granted requester in IDLE
//   rsp_valid/id/data/carry          registered result, stable while rsp_ready is low
//   rsp_ready                        consumer takes the result
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OPW   = alu_pkg::OPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   input  logic             rsp_ready
);

   state_t           state_reg;
   logic             prio_reg;   // requester that wins when both are valid
   logic [OPW-1:0]   op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             id_reg;

   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] core_result;
   logic             core_carry;

   // A lone valid requester always wins; a tie goes to prio_reg.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || !prio_reg);
      grant1 = req1_valid && (!req0_valid ||  prio_reg);
   end

   assign req0_ready = (state_reg == IDLE) && grant0;
   assign req1_ready = (state_reg == IDLE) && grant1;

   alu_core #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_core (
      .op     (op_reg),
      .a      (a_reg),
      .b      (b_reg),
      .result (core_result),
      .carry  (core_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         prio_reg  <= 1'b0;
         op_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         id_reg    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  op_reg    <= req1_ready ? req1_op : req0_op;
                  a_reg     <= req1_ready ? req1_a  : req0_a;
                  b_reg     <= req1_ready ? req1_b  : req0_b;
                  id_reg    <= req1_ready;
                  // Hand the tie-break to whoever was not just served.
                  prio_reg  <= ~req1_ready;
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= core_result;
               rsp_carry <= core_carry;
               rsp_id    <= id_reg;
               rsp_valid <= 1'b1;
               state_reg <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses,
// filled at each request handshake and drained by a response monitor.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp_valid, rsp_id, rsp_carry, rsp_ready;
   logic [3:0] rsp_data;

   typedef struct packed {
      logic       id;
      logic [3:0] data;
      logic       carry;
   } exp_t;

   exp_t sb[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_carry  (rsp_carry),
      .rsp_ready  (rsp_ready)
   );

   // Reference model using integer arithmetic.
   function automatic exp_t model(input logic id, input logic [2:0] op,
                                  input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int   ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      e.id = id;
      e.carry = 1'b0;
      e.data = 4'b0000;
      case (op)
         3'd0: e.data = a & b;
         3'd1: e.data = a | b;
         3'd2: e.data = a ^ b;
         3'd3: e.data = ~(a ^ b);
         3'd4: e.data = ~(a & b);
         3'd5: e.data = ~(a | b);
         3'd6: begin
            r = ia + ib;
            e.data  = 4'(r % 16);
            e.carry = (r > 15);
         end
         default: begin
            r = ia - ib;
            e.data  = 4'((r + 16) % 16);
            e.carry = (r < 0);
         end
      endcase
      return e;
   endfunction

   // Response monitor: every consumed response is compared to the scoreboard head.
   always @(negedge clk) begin
      if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         chk_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL rsp_unexpected: got id=%0d data=%b carry=%0d, required no response",
                     rsp_id, rsp_data, rsp_carry);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_carry} !== e)
               $display("FAIL rsp_compare: got id=%0d data=%b carry=%0d, required id=%0d data=%b carry=%0d",
                        rsp_id, rsp_data, rsp_carry, e.id, e.data, e.carry);
            else
               pass_cnt++;
         end
      end
   end

   // Drive one request and wait (bounded) for its handshake. Starts and ends just after a posedge.
   task automatic issue(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, output bit to);
      to = 1'b1;
      if (id) begin
         req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            sb.push_back(model(id, op, a, b));
            to = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   // Wait (bounded) for the scoreboard to empty, then realign after a posedge.
   task automatic drain(output bit to);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready} !== 9'b0)
         $display("FAIL reset_outputs: got valid=%b id=%b data=%b carry=%b rdy0=%b rdy1=%b, required all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready);
      else
         pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_xnor_latency();
      rsp_ready = 1'b1;
      req0_op = 3'b011; req0_a = 4'b1010; req0_b = 4'b1100; req0_valid = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'b01)
         $display("FAIL xnor_grant: got rdy1/rdy0=%b, required 01", {req1_ready, req0_ready});
      else
         pass_cnt++;
      if (req0_ready === 1'b1) sb.push_back(model(1'b0, 3'b011, 4'b1010, 4'b1100));
      @(posedge clk); #1;
      // Operands change after the handshake; they must not reach the result.
      req0_valid = 1'b0; req0_a = 4'b0000; req0_b = 4'b1111;
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, req0_ready} !== 2'b00)
         $display("FAIL xnor_exec_cycle: got valid=%b rdy0=%b, required 0 0", rsp_valid, req0_ready);
      else
         pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1)
         $display("FAIL xnor_latency: got rsp_valid=%b in third cycle, required 1", rsp_valid);
      else
         pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b0)
         $display("FAIL xnor_release: got rsp_valid=%b after rsp_ready, required 0", rsp_valid);
      else
         pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_alu_ops();
      logic [11:0] tbl [16];
      bit          to;
      // {id, op, a, b} packed as 1+3+4+4 bits
      tbl[0] = {1'b1, 3'b110, 4'b1111, 4'b0001};
      tbl[1] = {1'b1, 3'b111, 4'b0011, 4'b0101};
      tbl[2] = {1'b1, 3'b111, 4'b0101, 4'b0011};
      tbl[3] = {1'b0, 3'b100, 4'b1100, 4'b1010};
      tbl[4] = {1'b1, 3'b101, 4'b1000, 4'b0010};
      tbl[5] = {1'b0, 3'b000, 4'b1110, 4'b0111};
      tbl[6] = {1'b0, 3'b001, 4'b1000, 4'b0001};
      tbl[7] = {1'b1, 3'b010, 4'b1111, 4'b0101};
      tbl[8] = {1'b0, 3'b111, 4'b0111, 4'b0111};
      tbl[9] = {1'b1, 3'b110, 4'b0111, 4'b0110};
      for (int i = 10; i < 16; i++) tbl[i] = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 16; i++) begin
         issue(tbl[i][11], tbl[i][10:8], tbl[i][7:4], tbl[i][3:0], to);
         chk_cnt++;
         if (to) $display("FAIL ops_handshake: entry %0d got no ready, required ready", i);
         else pass_cnt++;
         drain(to);
         chk_cnt++;
         if (to) $display("FAIL ops_response: entry %0d got no response, required one", i);
         else pass_cnt++;
      end
   endtask

   task automatic test_arbitration();
      bit         to;
      logic [1:0] g;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req0_op = 3'b000; req0_a = 4'b1111; req0_b = 4'b0001; req0_valid = 1'b1;
      req1_op = 3'b001; req1_a = 4'b1010; req1_b = 4'b0101; req1_valid = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'b01)
         $display("FAIL arb_tie_reset: got rdy1/rdy0=%b, required 01", {req1_ready, req0_ready});
      else
         pass_cnt++;
      if (req0_ready === 1'b1) sb.push_back(model(1'b0, 3'b000, 4'b1111, 4'b0001));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      issue(1'b1, 3'b001, 4'b1010, 4'b0101, to);
      chk_cnt++;
      if (to) $display("FAIL arb_pending: got no ready for requester 1, required ready");
      else pass_cnt++;
      drain(to);
      chk_cnt++;
      if (to) $display("FAIL arb_drain1: got missing responses, required both");
      else pass_cnt++;

      // prio is back at 0: requester 0 wins, then requester 1 wins the next tie.
      req0_op = 3'b010; req0_a = 4'b0110; req0_b = 4'b0011; req0_valid = 1'b1;
      req1_op = 3'b110; req1_a = 4'b1000; req1_b = 4'b1000; req1_valid = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'b01)
         $display("FAIL arb_tie_again: got rdy1/rdy0=%b, required 01", {req1_ready, req0_ready});
      else
         pass_cnt++;
      if (req0_ready === 1'b1) sb.push_back(model(1'b0, 3'b010, 4'b0110, 4'b0011));
      @(posedge clk); #1;
      req0_op = 3'b111; req0_a = 4'b0001; req0_b = 4'b0010;
      g = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            g = {req1_ready, req0_ready};
            break;
         end
      end
      chk_cnt++;
      if (g !== 2'b10)
         $display("FAIL arb_round_robin: got rdy1/rdy0=%b, required 10", g);
      else
         pass_cnt++;
      if (g === 2'b10) sb.push_back(model(1'b1, 3'b110, 4'b1000, 4'b1000));
      @(posedge clk); #1;
      req1_valid = 1'b0;
      issue(1'b0, 3'b111, 4'b0001, 4'b0010, to);
      chk_cnt++;
      if (to) $display("FAIL arb_loser: got no ready for requester 0, required ready");
      else pass_cnt++;
      drain(to);
      chk_cnt++;
      if (to) $display("FAIL arb_drain2: got missing responses, required all");
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit   to;
      exp_t e;
      rsp_ready = 1'b0;
      issue(1'b1, 3'b110, 4'b0111, 4'b0011, to);
      chk_cnt++;
      if (to) $display("FAIL bp_handshake: got no ready, required ready");
      else pass_cnt++;
      to = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
      chk_cnt++;
      if (to) $display("FAIL bp_rsp_valid: got rsp_valid=0, required 1");
      else pass_cnt++;
      e = model(1'b1, 3'b110, 4'b0111, 4'b0011);
      // Both requesters knock while the result is held.
      req0_op = 3'b000; req0_a = 4'b1100; req0_b = 4'b0110; req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready} !== {1'b1, e, 2'b00})
            $display("FAIL bp_hold: cycle %0d got valid=%b id=%b data=%b carry=%b rdy0=%b rdy1=%b, required valid=1 id=%b data=%b carry=%b rdy=00",
                     i, rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready, e.id, e.data, e.carry);
         else
            pass_cnt++;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req1_valid = 1'b0;
      @(negedge clk);           // monitor consumes the held response here
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, req0_ready} !== 2'b01)
         $display("FAIL bp_release_idle: got valid=%b rdy0=%b, required valid=0 rdy0=1", rsp_valid, req0_ready);
      else
         pass_cnt++;
      if (req0_ready === 1'b1) sb.push_back(model(1'b0, 3'b000, 4'b1100, 4'b0110));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      drain(to);
      chk_cnt++;
      if (to) $display("FAIL bp_drain: got missing responses, required all");
      else pass_cnt++;
   endtask

   task automatic test_reset_exec();
      bit to;
      bit seen;
      rsp_ready = 1'b1;
      issue(1'b0, 3'b110, 4'b0110, 4'b0111, to);
      chk_cnt++;
      if (to) $display("FAIL rst_exec_handshake: got no ready, required ready");
      else pass_cnt++;
      // Now in EXEC: kill the transaction, no response may follow.
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready} !== 9'b0)
         $display("FAIL rst_exec_outputs: got valid=%b id=%b data=%b carry=%b rdy0=%b rdy1=%b, required all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready);
      else
         pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      chk_cnt++;
      if (seen) $display("FAIL rst_exec_discard: got rsp_valid=1 after reset, required 0");
      else pass_cnt++;
      @(posedge clk); #1;
      issue(1'b0, 3'b101, 4'b0000, 4'b0000, to);
      chk_cnt++;
      if (to) $display("FAIL rst_exec_nor_handshake: got no ready, required ready");
      else pass_cnt++;
      drain(to);
      chk_cnt++;
      if (to) $display("FAIL rst_exec_nor_response: got no response, required one");
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_xnor_latency();
      test_alu_ops();
      test_arbitration();
      test_backpressure();
      test_reset_exec();
      chk_cnt++;
      if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d left, required 0", sb.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
